// File: rtl/pu_msp430_arb_pkg.sv
// Shared types for the MSP430 data-memory arbiter.
//   owner_e     : which requester owns the read data returning next cycle
//   arb_state_e : arbiter FSM state (normal arbitration / locked DMA burst)
package pu_msp430_arb_pkg;

  typedef enum logic [1:0] {NONE, DBG, EU, DMA} owner_e;

  typedef enum logic {ARB, DMA_LOCK} arb_state_e;

endpackage

// File: rtl/pu_msp430_sat_counter.sv
// Saturating up-counter with clear and a saturation flag.
//   mclk      : clock
//   puc_rst_n : synchronous active-low reset
//   inc       : count up (held at MAX once saturated)
//   clr       : restart; with inc also high the counter restarts at 1
//   sat       : counter equals MAX
module pu_msp430_sat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic mclk,
  input  logic puc_rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt_q;

  assign sat = (cnt_q == W'(MAX));

  always_ff @(posedge mclk) begin
    if (!puc_rst_n)        cnt_q <= '0;
    else if (clr)          cnt_q <= inc ? W'(1) : '0;
    else if (inc && !sat)  cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/pu_msp430_dmem_arbiter.sv
// Three-way data-memory arbiter (debug, execution unit, DMA) with
// zero-latency combinational grant, DMA starvation promotion and locked
// DMA bursts.
//   mclk, puc_rst_n          : clock, synchronous active-low reset
//   X_req/addr/wr/wdata      : request per requester (wr=00 is a read)
//   X_gnt                    : request accepted this cycle
//   X_rdata/X_rvalid         : read data, valid one cycle after a read grant
//   dma_lock                 : DMA wants to keep the port on following cycles
//   dmem_cen/addr/wen/din    : memory port (cen, wen low active)
//   dmem_dout                : memory read data, one cycle after access
module pu_msp430_dmem_arbiter
  import pu_msp430_arb_pkg::*;
#(
  parameter int AW         = 15,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic          mclk,
  input  logic          puc_rst_n,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  input  logic [1:0]    dbg_wr,
  input  logic [15:0]   dbg_wdata,
  output logic          dbg_gnt,
  output logic [15:0]   dbg_rdata,
  output logic          dbg_rvalid,
  input  logic          eu_req,
  input  logic [AW-1:0] eu_addr,
  input  logic [1:0]    eu_wr,
  input  logic [15:0]   eu_wdata,
  output logic          eu_gnt,
  output logic [15:0]   eu_rdata,
  output logic          eu_rvalid,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [1:0]    dma_wr,
  input  logic [15:0]   dma_wdata,
  output logic          dma_gnt,
  output logic [15:0]   dma_rdata,
  output logic          dma_rvalid,
  input  logic          dma_lock,
  output logic          dmem_cen,
  output logic [AW-1:0] dmem_addr,
  output logic [1:0]    dmem_wen,
  output logic [15:0]   dmem_din,
  input  logic [15:0]   dmem_dout
);

  arb_state_e    state_q, state_d;
  owner_e        own_q, own_d;
  logic          starve_sat, lock_sat, lock_leave;
  logic          dbg_win, eu_win, dma_win;
  logic          st_inc, st_clr, lk_inc, lk_clr;
  logic [1:0]    wr_sel;

  // Winner select. Reset forces every grant low.
  always_comb begin
    dbg_win = 1'b0;
    eu_win  = 1'b0;
    dma_win = 1'b0;
    if (puc_rst_n) begin
      if (dbg_req)                               dbg_win = 1'b1;
      else if (state_q == DMA_LOCK && dma_req)   dma_win = 1'b1;
      else if (starve_sat && dma_req)            dma_win = 1'b1;
      else if (eu_req)                           eu_win  = 1'b1;
      else if (dma_req)                          dma_win = 1'b1;
    end
  end

  assign dbg_gnt = dbg_win;
  assign eu_gnt  = eu_win;
  assign dma_gnt = dma_win;

  always_comb begin
    state_d    = state_q;
    lock_leave = 1'b0;
    case (state_q)
      ARB:      if (dma_win && dma_lock) state_d = DMA_LOCK;
      DMA_LOCK: if (!dma_lock || !dma_req || dbg_req || lock_sat) begin
                  state_d    = ARB;
                  lock_leave = 1'b1;
                end
      default:  state_d = ARB;
    endcase
  end

  // Starvation: a denied cycle counts up, a grant or idle DMA restarts it.
  // Leaving a lock also restarts it, even if dbg just preempted the DMA.
  assign st_clr = dma_win || !dma_req || lock_leave;
  assign st_inc = dma_req && !dma_win && !lock_leave;

  // Lock counter holds the number of burst grants already issued; the
  // entry grant in ARB loads 1, so saturating at LOCK_MAX-1 marks the
  // DMA_LOCK cycle that issues the final grant of the burst.
  assign lk_clr = (state_q == ARB) || lock_leave;
  assign lk_inc = (state_q == ARB) ? (dma_win && dma_lock) : !lock_leave;

  pu_msp430_sat_counter #(.MAX(STARVE_MAX)) u_starve_cnt (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .inc(st_inc), .clr(st_clr), .sat(starve_sat)
  );

  pu_msp430_sat_counter #(.MAX(LOCK_MAX - 1)) u_lock_cnt (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .inc(lk_inc), .clr(lk_clr), .sat(lock_sat)
  );

  // Memory port mux; idle leaves address/data at zero.
  always_comb begin
    dmem_addr = '0;
    dmem_din  = '0;
    wr_sel    = 2'b00;
    own_d     = NONE;
    if (dbg_win) begin
      dmem_addr = dbg_addr; dmem_din = dbg_wdata; wr_sel = dbg_wr;
      if (dbg_wr == 2'b00) own_d = DBG;
    end else if (eu_win) begin
      dmem_addr = eu_addr;  dmem_din = eu_wdata;  wr_sel = eu_wr;
      if (eu_wr == 2'b00) own_d = EU;
    end else if (dma_win) begin
      dmem_addr = dma_addr; dmem_din = dma_wdata; wr_sel = dma_wr;
      if (dma_wr == 2'b00) own_d = DMA;
    end
  end

  assign dmem_cen = ~(dbg_win | eu_win | dma_win);
  assign dmem_wen = ~wr_sel;

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state_q <= ARB;
      own_q   <= NONE;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
    end
  end

  // rvalid is also masked by reset so a read in flight when reset
  // arrives never reports data.
  assign dbg_rvalid = puc_rst_n && (own_q == DBG);
  assign eu_rvalid  = puc_rst_n && (own_q == EU);
  assign dma_rvalid = puc_rst_n && (own_q == DMA);

  assign dbg_rdata = dmem_dout;
  assign eu_rdata  = dmem_dout;
  assign dma_rdata = dmem_dout;

endmodule

// File: tb/tb_pu_msp430_dmem_arbiter.sv
// Scoreboard bench for pu_msp430_dmem_arbiter: directed per-cycle vectors
// push their expected response, a negedge monitor pops and compares.
module tb_pu_msp430_dmem_arbiter;
  localparam int AW = 15;
  localparam logic [AW-1:0] DBG_A = 15'h0100, EU_A = 15'h0010, DMA_A = 15'h0200;
  localparam logic [15:0]   DBG_D = 16'hDB01, EU_D = 16'hE002, DMA_D = 16'hD0A3;
  localparam logic [1:0]    R = 2'b00, W = 2'b11;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic puc_rst_n = 1'b0;
  logic dbg_req = 0, eu_req = 0, dma_req = 0, dma_lock = 0;
  logic [1:0] dbg_wr = R, eu_wr = R, dma_wr = R;
  logic [15:0] dmem_dout = '0;
  logic dbg_gnt, eu_gnt, dma_gnt, dbg_rvalid, eu_rvalid, dma_rvalid;
  logic [15:0] dbg_rdata, eu_rdata, dma_rdata, dmem_din;
  logic dmem_cen;
  logic [1:0] dmem_wen;
  logic [AW-1:0] dmem_addr;

  pu_msp430_dmem_arbiter #(.AW(AW), .STARVE_MAX(4), .LOCK_MAX(8)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n),
    .dbg_req(dbg_req), .dbg_addr(DBG_A), .dbg_wr(dbg_wr), .dbg_wdata(DBG_D),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .eu_req(eu_req), .eu_addr(EU_A), .eu_wr(eu_wr), .eu_wdata(EU_D),
    .eu_gnt(eu_gnt), .eu_rdata(eu_rdata), .eu_rvalid(eu_rvalid),
    .dma_req(dma_req), .dma_addr(DMA_A), .dma_wr(dma_wr), .dma_wdata(DMA_D),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dma_lock(dma_lock),
    .dmem_cen(dmem_cen), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_din(dmem_din), .dmem_dout(dmem_dout)
  );

  typedef struct {
    logic [2:0]    gnt;   // {dbg, eu, dma}
    logic [2:0]    rv;
    logic          cen;
    logic [1:0]    wen;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [15:0]   rdata;
    int            id;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0, vec = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, id, act, exp);
    end
  endtask

  // One cycle of stimulus plus its hand-computed grant/rvalid expectation.
  task automatic cyc(input logic rst, input logic d, e, m, lk,
                     input logic [1:0] dwr, ewr, mwr,
                     input logic [2:0] eg, input logic [2:0] erv);
    exp_t x;
    @(posedge mclk); #1;
    puc_rst_n = rst; dbg_req = d; eu_req = e; dma_req = m; dma_lock = lk;
    dbg_wr = dwr; eu_wr = ewr; dma_wr = mwr;
    vec++;
    dmem_dout = 16'h5A00 + 16'(vec);
    x.gnt = eg; x.rv = erv; x.cen = (eg == 3'b000);
    x.wen = 2'b11; x.addr = '0; x.din = '0; x.id = vec;
    if (eg[2])      begin x.wen = ~dwr; x.addr = DBG_A; x.din = DBG_D; end
    else if (eg[1]) begin x.wen = ~ewr; x.addr = EU_A;  x.din = EU_D;  end
    else if (eg[0]) begin x.wen = ~mwr; x.addr = DMA_A; x.din = DMA_D; end
    x.rdata = dmem_dout;
    sb.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge mclk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("gnt",    x.id, {29'd0, dbg_gnt, eu_gnt, dma_gnt}, {29'd0, x.gnt});
        chk("rvalid", x.id, {29'd0, dbg_rvalid, eu_rvalid, dma_rvalid}, {29'd0, x.rv});
        chk("cen",    x.id, {31'd0, dmem_cen}, {31'd0, x.cen});
        chk("wen",    x.id, {30'd0, dmem_wen}, {30'd0, x.wen});
        chk("addr",   x.id, {17'd0, dmem_addr}, {17'd0, x.addr});
        chk("din",    x.id, {16'd0, dmem_din}, {16'd0, x.din});
        if (x.rv[2]) chk("dbg_rdata", x.id, {16'd0, dbg_rdata}, {16'd0, x.rdata});
        if (x.rv[1]) chk("eu_rdata",  x.id, {16'd0, eu_rdata},  {16'd0, x.rdata});
        if (x.rv[0]) chk("dma_rdata", x.id, {16'd0, dma_rdata}, {16'd0, x.rdata});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // reset: requests ignored
    cyc(0,0,1,0,0, R,R,R, 3'b000,3'b000);
    cyc(0,0,1,0,0, R,R,R, 3'b000,3'b000);
    // lone eu read, data next cycle
    cyc(1,0,1,0,0, R,R,R, 3'b010,3'b000);
    cyc(1,0,0,0,0, R,R,R, 3'b000,3'b010);
    // eu byte write: no rvalid afterwards
    cyc(1,0,1,0,0, R,2'b01,R, 3'b010,3'b000);
    cyc(1,0,0,0,0, R,R,R, 3'b000,3'b000);
    // dbg beats eu, eu follows
    cyc(1,1,1,0,0, R,R,R, 3'b100,3'b000);
    cyc(1,0,1,0,0, R,R,R, 3'b010,3'b100);
    cyc(1,0,0,0,0, R,R,R, 3'b000,3'b010);
    // eu+dma contention: 4 eu then 1 dma, repeating
    for (int i = 0; i < 10; i++)
      cyc(1,0,1,1,0, R,R,R, (i % 5 == 4) ? 3'b001 : 3'b010,
          (i == 0) ? 3'b000 : (((i - 1) % 5 == 4) ? 3'b001 : 3'b010));
    cyc(1,0,0,0,0, R,R,R, 3'b000,3'b001);
    // locked dma write burst with eu pending
    for (int i = 0; i < 4; i++)
      cyc(1,0,1,1,1, R,R,W, 3'b010, (i == 0) ? 3'b000 : 3'b010);
    for (int i = 0; i < 8; i++)
      cyc(1,0,1,1,1, R,R,W, 3'b001, (i == 0) ? 3'b010 : 3'b000);
    cyc(1,0,1,1,1, R,R,W, 3'b010,3'b000);
    // relock, then dbg preempts on lock cycle 3
    cyc(1,0,0,1,1, R,R,W, 3'b001,3'b010);
    cyc(1,0,0,1,1, R,R,W, 3'b001,3'b000);
    cyc(1,0,0,1,1, R,R,W, 3'b001,3'b000);
    cyc(1,1,0,1,1, R,R,W, 3'b100,3'b000);
    cyc(1,0,1,1,1, R,R,W, 3'b010,3'b100);   // back in ARB: eu wins
    cyc(1,0,0,0,0, R,R,R, 3'b000,3'b010);
    // reset right after an eu read grant, with starvation count at 2
    cyc(1,0,1,1,0, R,R,R, 3'b010,3'b000);
    cyc(1,0,1,1,0, R,R,R, 3'b010,3'b010);
    cyc(0,0,1,1,0, R,R,R, 3'b000,3'b000);
    cyc(0,0,1,1,0, R,R,R, 3'b000,3'b000);
    for (int i = 0; i < 5; i++)
      cyc(1,0,1,1,0, R,R,R, (i == 4) ? 3'b001 : 3'b010, (i == 0) ? 3'b000 : 3'b010);
    cyc(1,0,0,0,0, R,R,R, 3'b000,3'b001);
    cyc(1,0,0,0,0, R,R,R, 3'b000,3'b000);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge mclk);
    @(posedge mclk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pu_msp430_dmem_arbiter.md
PU_MSP430_DMEM_ARBITER -- requirements
Module: pu_msp430_dmem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: AW, 15, word-address width; STARVE_MAX, 4, max consecutive DMA-denied cycles; LOCK_MAX, 8, max cycles of a locked DMA burst.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-003 mclk  in  1  main system clock; all state updates on its rising edge.
REQ-004 puc_rst_n  in  1  synchronous active-low reset.
REQ-005 For each requester X in {dbg, eu, dma}: X_req in 1 request; X_addr in AW word address; X_wr in 2 byte write strobes (00 = read); X_wdata in 16 write data.
REQ-006 For each X: X_gnt out 1 access accepted this cycle; X_rdata out 16 read data; X_rvalid out 1 read data valid.
REQ-007 dma_lock  in  1  DMA asks to keep ownership on following cycles (burst).
REQ-008 dmem_cen out 1 chip enable, low active; dmem_addr out AW; dmem_wen out 2, low active; dmem_din out 16; dmem_dout in 16 memory read data, valid one cycle after access.

Function
REQ-009 At most one X_gnt SHALL be high per cycle; grant is combinational from current requests and registered state (zero-latency acceptance).
REQ-010 Default priority SHALL be dbg > eu > dma.
REQ-011 Memory port SHALL carry the granted requester's addr/wdata; dmem_cen = ~(any grant); dmem_wen = ~winner_wr when granted, 2'b11 otherwise.
REQ-012 Read data SHALL return exactly one cycle after a read grant: X_rvalid high for one cycle only for the owner registered at grant; X_rdata = dmem_dout for all X (qualified by rvalid); no rvalid for writes.
REQ-013 Starvation counter SHALL increment each cycle dma_req is high and dma_gnt low, clear when dma_gnt high or dma_req low, saturate at STARVE_MAX.
REQ-014 When counter == STARVE_MAX and dbg_req low, dma SHALL win over eu for that cycle.
REQ-015 FSM states SHALL be ARB and DMA_LOCK; ARB -> DMA_LOCK when dma granted with dma_lock high; DMA_LOCK -> ARB when dma_lock low, dma_req low, dbg_req high, or lock counter reaches LOCK_MAX.
REQ-016 In DMA_LOCK, dma SHALL be granted whenever dma_req high, except dbg_req high preempts (dbg granted, state returns to ARB same edge).
REQ-017 Lock counter SHALL load 1 on ARB -> DMA_LOCK, increment each DMA_LOCK cycle, exit when reaching LOCK_MAX; leaving lock SHALL clear the starvation counter; re-lock requires one ARB cycle.
REQ-018 Simultaneous eu_req and dma_req with counter below STARVE_MAX SHALL grant eu and increment counter.
REQ-019 Idle cycles (no req) SHALL keep dmem_cen = 1, addr/din held at zero.

Reset
REQ-020 While puc_rst_n low at a clock edge: state = ARB, both counters = 0, registered owner = NONE; all X_rvalid = 0 on the following cycle.
REQ-021 Grants SHALL be forced to 0 and dmem_cen = 1 while puc_rst_n low; a read granted the cycle before reset produces no rvalid.

Structure
REQ-022 Shared package pu_msp430_arb_pkg SHALL hold the owner enum (NONE, DBG, EU, DMA) and the FSM state enum (ARB, DMA_LOCK).
REQ-023 One sub-module pu_msp430_sat_counter (width/max parameters, inc, clr, sat flag) SHALL be instantiated twice: starvation and lock counters.
REQ-024 No other hierarchy; target 150-300 lines RTL.

Verification
REQ-025 eu read addr 0x0010 alone -> eu_gnt same cycle, dmem_cen=0, dmem_wen=11; next cycle eu_rvalid=1, eu_rdata=dmem_dout.
REQ-026 dbg and eu request same cycle -> dbg_gnt=1, eu_gnt=0; eu granted next cycle when dbg drops.
REQ-027 eu and dma request continuously -> eu granted cycles 1-4, dma granted cycle 5, counter reset, pattern repeats.
REQ-028 dma write with dma_lock held and eu_req high -> dma granted 8 consecutive cycles, then one eu grant before dma relocks.
REQ-029 dbg_req during DMA_LOCK cycle 3 -> dbg_gnt that cycle, state ARB next cycle, no dma grant that cycle.
REQ-030 puc_rst_n low the cycle after an eu read grant -> no eu_rvalid, all grants 0, counters 0 after release.
